pipo_rr_arbiter: RTL and testbench
==================================

# pipo_rr_arbiter

Round-robin arbiter and sequencer that shares a single 32-bit parallel-in/parallel-out holding register among NREQ requesters. It picks one pending requester, loads that requester's word into the register, and presents it downstream with a valid/ack handshake. It sits between the producer ports and the shared PIPO stage. It replaces ad-hoc direct wiring of one producer to the register.

## Interface
- WIDTH, 32, data word width of the shared register
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), width of owner id (derived, not overridden)

- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- req  in  NREQ  per-requester request, level-sensitive
- data_in  in  NREQ*WIDTH  requester i word on bits [i*WIDTH +: WIDTH]
- grant  out  NREQ  registered one-hot pulse, one cycle, marks the requester whose word was loaded
- answer  out  WIDTH  shared register contents
- owner  out  IDW  index of the requester whose word is in answer
- out_valid  out  1  answer holds an unconsumed word
- out_ack  in  1  downstream consumes answer when sampled high with out_valid
- xfer_count  out  16  number of completed loads, wraps 0xFFFF -> 0x0000

## Operation
- Two states: IDLE (out_valid=0) and HOLD (out_valid=1).
- Winner selection: the first i with req[i]=1, scanning from ptr upward modulo NREQ. ptr is an internal round-robin pointer.
- A load happens at an edge where state=IDLE and |req, or where state=HOLD, out_ack=1 and |req. On a load:
  - answer <= winner word
  - owner <= winner
  - grant <= onehot(winner)
  - ptr <= (winner+1) mod NREQ
  - xfer_count += 1
  - state <= HOLD
- At an edge in HOLD with out_ack=1 and no req: state <= IDLE, out_valid <= 0. answer and owner keep their last values.
- At an edge in HOLD with out_ack=0: nothing changes. answer is stable, and req is ignored. A requester must hold req and data_in until it sees its grant.
- In IDLE, out_ack is ignored.
- A requester may drop req before it is granted. It is simply skipped.
- Starvation bound: a requester that holds req is granted within NREQ loads.

## Timing
- Reset values: state=IDLE, ptr=0, grant=0, answer=0, owner=0, out_valid=0, xfer_count=0.
- Latency: req first seen high in IDLE at edge k. At edge k, answer, owner, grant and out_valid update; they are visible in cycle k+1.
- grant is high for exactly the cycle after the load edge.
- Back-to-back: with out_ack tied high and requests pending, one load per cycle. out_valid stays high, and grant moves each cycle.
- Simultaneous ack and new req in HOLD: the new load happens at that edge. There is no IDLE bubble.
- If reset is asserted in HOLD, any pending word is discarded. Outputs return to reset values asynchronously. The first load after reset release starts the scan at requester 0.
- Pointer wrap: a winner of NREQ-1 sets ptr to 0.

## Structure
- Package pipo_ctrl_pkg contains:
  - state enum {IDLE, HOLD}
  - default WIDTH and NREQ constants
  - the onehot helper function
- Sub-module rr_pick: combinational. Inputs are req and ptr; outputs are winner index and any_req. It is reused by other shared-resource arbiters.
- The top level holds the FSM, the register, ptr and the counter.

## Test plan
- Reset: hold reset=0 with random req and data, then release. All outputs are 0, and there is no grant until req is seen.
- Single requester: req=4'b0100, data_in[2]=32'h7FFFFFFF. The cycle after the edge shows answer=32'h7FFFFFFF, owner=2, grant=4'b0100 for 1 cycle, out_valid=1. With out_ack=0 held for 5 cycles, all of these stay constant. After the ack edge, out_valid=0 and xfer_count=1.
- Fairness: req=4'b1111, out_ack=1 constantly. Owners are 0,1,2,3,0,... over 8 cycles, and xfer_count reaches 8.
- Wrap and skip: req=4'b1001 with ptr at 0. Owners alternate 0,3,0,3.
- Mid-operation reset: in HOLD with answer=32'hDEADBEEF, pulse reset low asynchronously, between edges. answer=0 and out_valid=0 immediately. Then with req=4'b0010, owner=1.
- Counter wrap: force 65536 loads. xfer_count returns to 0x0000.

Source files
------------

// File: rtl/pipo_ctrl_pkg.sv
// Shared types and helpers for the round-robin PIPO arbiter and related
// shared-resource arbiters.
package pipo_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned MAX_NREQ  = 16;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [31:0] idx);
        logic [MAX_NREQ-1:0] v;
        v = '0;
        v[idx[3:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  winner,
    output logic            any_req
);

    logic [31:0] idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!any_req && req[idx[IDW-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter sharing one PIPO holding register among NREQ producers,
// presented downstream through a valid/ack handshake.
module pipo_rr_arbiter
    import pipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      answer,
    output logic [IDW-1:0]        owner,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [15:0]           xfer_count
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   winner;
    logic             any_req;
    logic             load;
    logic [NREQ-1:0]  grant_q;
    logic [WIDTH-1:0] answer_q;
    logic [IDW-1:0]   owner_q;
    logic [15:0]      count_q;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any_req) state_d = HOLD;
            HOLD: if (out_ack && !any_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A load replaces the held word only once downstream has taken it.
    always_comb begin
        load      = any_req && ((state_q == IDLE) || out_ack);
        out_valid = (state_q == HOLD);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q    <= '0;
            grant_q  <= '0;
            answer_q <= '0;
            owner_q  <= '0;
            count_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= load ? NREQ'(onehot(32'(winner))) : '0;
            if (load) begin
                answer_q <= data_in[winner*WIDTH +: WIDTH];
                owner_q  <= winner;
                count_q  <= count_q + 16'd1;
            end
        end
    end

    assign grant      = grant_q;
    assign answer     = answer_q;
    assign owner      = owner_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Directed bench for pipo_rr_arbiter with a behavioural model and a
// scoreboard of expected loads.
module tb_pipo_rr_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 4;

    typedef struct {
        int          owner;
        logic [31:0] word;
    } exp_t;

    logic               clock;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [31:0]        words [NREQ];
    logic [NREQ*32-1:0] data_in;
    logic [NREQ-1:0]    grant;
    logic [WIDTH-1:0]   answer;
    logic [1:0]         owner;
    logic               out_valid;
    logic               out_ack;
    logic [15:0]        xfer_count;

    int          checks;
    int          failures;
    exp_t        sb[$];
    int          m_ptr;
    logic [15:0] m_count;
    logic        m_hold;
    logic [31:0] m_answer;
    int          m_owner;

    assign data_in = {words[3], words[2], words[1], words[0]};

    pipo_rr_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .data_in    (data_in),
        .grant      (grant),
        .answer     (answer),
        .owner      (owner),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .xfer_count (xfer_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr    = 0;
        m_count  = 16'd0;
        m_hold   = 1'b0;
        m_answer = 32'd0;
        m_owner  = 0;
        sb.delete();
    endfunction

    // Drive one cycle, predict from the model, then compare after the edge.
    task automatic drive_step(input logic [3:0] r, input logic a, output int got_owner);
        exp_t e;
        int   w;
        logic exp_load;
        req      = r;
        out_ack  = a;
        exp_load = (r != 4'b0) && (!m_hold || a);
        got_owner = -1;
        if (exp_load) begin
            w       = pick(r, m_ptr);
            sb.push_back('{owner: w, word: words[w]});
            m_ptr   = (w + 1) % 4;
            m_count = m_count + 16'd1;
            m_hold  = 1'b1;
        end else if (m_hold && a) begin
            m_hold = 1'b0;
        end
        @(posedge clock);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_hold));
        check("xfer_count", 64'(xfer_count), 64'(m_count));
        if (exp_load) begin
            e         = sb.pop_front();
            m_answer  = e.word;
            m_owner   = e.owner;
            got_owner = 32'(owner);
            check("grant_load", 64'(grant), 64'(4'b0001 << e.owner));
        end else begin
            check("grant_idle", 64'(grant), 64'd0);
        end
        check("owner", 64'(owner), 64'(m_owner));
        check("answer", 64'(answer), 64'(m_answer));
    endtask

    initial begin
        int o;
        int fair_exp [8];
        int skip_exp [4];
        checks   = 0;
        failures = 0;
        model_reset();

        // Reset held with random activity on the inputs.
        reset   = 1'b0;
        req     = 4'($urandom);
        out_ack = 1'($urandom);
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        repeat (3) @(posedge clock);
        #1;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_answer", 64'(answer), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(xfer_count), 64'd0);
        req     = 4'b0;
        out_ack = 1'b0;
        reset   = 1'b1;
        drive_step(4'b0000, 1'b0, o);

        // Single requester, then stall for five cycles, then ack.
        words[2] = 32'h7FFF_FFFF;
        drive_step(4'b0100, 1'b0, o);
        check("single_answer", 64'(answer), 64'h7FFF_FFFF);
        check("single_owner", 64'(o), 64'd2);
        check("single_grant", 64'(grant), 64'b0100);
        for (int i = 0; i < 5; i++) drive_step(4'b0000, 1'b0, o);
        drive_step(4'b0000, 1'b1, o);
        check("single_count", 64'(xfer_count), 64'd1);
        check("single_valid", 64'(out_valid), 64'd0);

        // Fresh pointer for the fairness sweep.
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
        fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) words[j] = $urandom;
            drive_step(4'b1111, 1'b1, o);
            check("fair_owner", 64'(o), 64'(fair_exp[i]));
        end
        check("fair_count", 64'(xfer_count), 64'd8);

        // Wrap and skip: pointer is back at 0 after winner 3.
        skip_exp = '{0, 3, 0, 3};
        for (int i = 0; i < 4; i++) begin
            drive_step(4'b1001, 1'b1, o);
            check("skip_owner", 64'(o), 64'(skip_exp[i]));
        end
        drive_step(4'b0000, 1'b1, o);

        // Asynchronous reset in HOLD discards the word.
        words[0] = 32'hDEAD_BEEF;
        drive_step(4'b0001, 1'b0, o);
        check("pre_rst_answer", 64'(answer), 64'hDEAD_BEEF);
        req = 4'b0;
        #3;
        reset = 1'b0;
        #1;
        check("midrst_answer", 64'(answer), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(xfer_count), 64'd0);
        model_reset();
        #2;
        reset = 1'b1;
        drive_step(4'b0010, 1'b0, o);
        check("postrst_owner", 64'(o), 64'd1);
        drive_step(4'b0000, 1'b1, o);

        // Counter wrap: 65535 more loads bring the count back to zero.
        req     = 4'b1111;
        out_ack = 1'b1;
        repeat (65534) @(posedge clock);
        #1;
        m_count = m_count + 16'd65534;
        m_ptr   = (m_ptr + 65534) % 4;
        m_hold  = 1'b1;
        m_owner = (m_ptr + 3) % 4;
        m_answer = words[m_owner];
        drive_step(4'b1111, 1'b1, o);
        check("wrap_count", 64'(xfer_count), 64'd0);
        drive_step(4'b0000, 1'b1, o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
